// File: rtl/sig_ctrl_pkg.sv
// Shared types and default widths for the signal-generator sequencing controller.
// Widths match the 9-bit address counter feeding the dual-port waveform ROM.
package sig_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int WIDTH = 9;
    localparam int OFF_W = 8;
    localparam int DIV_W = 8;

endpackage

// File: rtl/sig_prescaler.sv
// Rate prescaler: emits one tick every div+1 cycles while run is high.
// The first tick lands in the first run cycle because the count idles at zero.
module sig_prescaler #(
    parameter int DIV_W = sig_ctrl_pkg::DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    import sig_ctrl_pkg::*;

    logic [DIV_W-1:0] div_cnt_reg;
    logic [DIV_W-1:0] div_cnt_next;

    // Decoded purely from registers so cnt_en has no path from any input.
    assign tick = run && (div_cnt_reg == '0);

    always_comb begin
        div_cnt_next = '0;
        if (run) begin
            if (div_cnt_reg == '0) begin
                div_cnt_next = div;
            end else begin
                div_cnt_next = div_cnt_reg - DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_next;
        end
    end

endmodule

// File: rtl/sig_ctrl.sv
// Sequencing controller for the dual-output address counter: start/stop FSM,
// prescaled enable, and offset updates that only take effect on a period wrap.
module sig_ctrl #(
    parameter int WIDTH = sig_ctrl_pkg::WIDTH,
    parameter int OFF_W = sig_ctrl_pkg::OFF_W,
    parameter int DIV_W = sig_ctrl_pkg::DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div,
    input  logic [OFF_W-1:0] offset_in,
    input  logic             offset_ld,
    input  logic             sweep,
    input  logic [WIDTH-1:0] count1,
    output logic             cnt_rst,
    output logic             cnt_en,
    output logic [OFF_W-1:0] offset,
    output logic             wrap,
    output logic             busy,
    output logic [1:0]       state
);
    import sig_ctrl_pkg::*;

    state_t           state_reg, state_next;
    logic [OFF_W-1:0] offset_reg, offset_next;
    logic [OFF_W-1:0] pend_reg, pend_next;
    logic             pend_val_reg, pend_val_next;
    logic             run;
    logic             tick;
    logic             wrap_ev;

    assign run = (state_reg == RUN) || (state_reg == HOLD);

    sig_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .div  (div),
        .tick (tick)
    );

    // The counter rolls over to zero on this same edge.
    assign wrap_ev = tick && (count1 == '1);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start && !stop) state_next = CLEAR;
            CLEAR:   state_next = stop ? IDLE : RUN;
            RUN:     if (stop) state_next = HOLD;
            HOLD:    if (wrap_ev) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outside RUN/HOLD loads go straight through; while running they are
    // deferred to the wrap so a period never changes phase mid-way.
    always_comb begin
        offset_next   = offset_reg;
        pend_next     = pend_reg;
        pend_val_next = pend_val_reg;
        if (!run) begin
            pend_val_next = 1'b0;
            if (offset_ld) begin
                offset_next = offset_in;
            end
        end else if (wrap_ev) begin
            pend_val_next = 1'b0;
            if (offset_ld) begin
                offset_next = offset_in;
            end else if (pend_val_reg) begin
                offset_next = pend_reg;
            end else if (sweep) begin
                offset_next = offset_reg + OFF_W'(1);
            end
        end else if (offset_ld) begin
            pend_next     = offset_in;
            pend_val_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            offset_reg   <= '0;
            pend_reg     <= '0;
            pend_val_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            offset_reg   <= offset_next;
            pend_reg     <= pend_next;
            pend_val_reg <= pend_val_next;
        end
    end

    assign cnt_rst = (state_reg == CLEAR);
    assign cnt_en  = tick;
    assign wrap    = wrap_ev;
    assign offset  = offset_reg;
    assign busy    = (state_reg != IDLE);
    assign state   = state_reg;

endmodule

// File: tb/tb_sig_ctrl.sv
// Bench for sig_ctrl: directed vector table and corner sequences, then random
// stimulus, all shadowed every cycle by an event-time reference model.
module tb_sig_ctrl;
    localparam int WIDTH = 9;
    localparam int OFF_W = 8;
    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [DIV_W-1:0] div = '0;
    logic [OFF_W-1:0] offset_in = '0;
    logic             offset_ld = 1'b0;
    logic             sweep = 1'b0;
    logic [WIDTH-1:0] count1 = '0;
    logic             cnt_rst, cnt_en, wrap, busy;
    logic [OFF_W-1:0] offset;
    logic [1:0]       state;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sig_ctrl #(
        .WIDTH (WIDTH),
        .OFF_W (OFF_W),
        .DIV_W (DIV_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .div       (div),
        .offset_in (offset_in),
        .offset_ld (offset_ld),
        .sweep     (sweep),
        .count1    (count1),
        .cnt_rst   (cnt_rst),
        .cnt_en    (cnt_en),
        .offset    (offset),
        .wrap      (wrap),
        .busy      (busy),
        .state     (state)
    );

    // Stand-in for the address counter driven by the controller.
    always @(posedge clk) begin
        if (cnt_rst) count1 <= '0;
        else if (cnt_en) count1 <= count1 + 1'b1;
    end

    // Reference model: strobes are scheduled as absolute cycle numbers.
    int     m_state = 0;
    int     m_off = 0;
    int     m_pend = 0;
    bit     m_pendv = 1'b0;
    longint cyc = 0;
    longint next_strobe = 0;
    int     m_en, m_wr;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state = 0;
            m_off   = 0;
            m_pend  = 0;
            m_pendv = 1'b0;
        end else begin
            m_en = (m_state >= 2 && cyc == next_strobe) ? 1 : 0;
            m_wr = (m_en == 1 && count1 == {WIDTH{1'b1}}) ? 1 : 0;
            if (m_state < 2) begin
                m_pendv = 1'b0;
                if (offset_ld) m_off = offset_in;
            end else if (m_wr == 1) begin
                if (offset_ld) m_off = offset_in;
                else if (m_pendv) m_off = m_pend;
                else if (sweep) m_off = (m_off + 1) % 256;
                m_pendv = 1'b0;
            end else if (offset_ld) begin
                m_pend  = offset_in;
                m_pendv = 1'b1;
            end
            if (m_state == 1) next_strobe = cyc + 1;
            else if (m_en == 1) next_strobe = cyc + longint'(div) + 1;
            case (m_state)
                0: if (start && !stop) m_state = 1;
                1: m_state = stop ? 0 : 2;
                2: if (stop) m_state = 3;
                default: if (m_wr == 1) m_state = 0;
            endcase
            cyc++;
        end
    end

    logic [13:0] exp_vec, act_vec;
    logic        e_en;

    always @(posedge clk) begin
        #2;
        if (rst) begin
            e_en    = (m_state >= 2) && (cyc == next_strobe);
            exp_vec = {2'(m_state), m_state != 0, m_state == 1, e_en,
                       e_en && (count1 == {WIDTH{1'b1}}), 8'(m_off)};
            act_vec = {state, busy, cnt_rst, cnt_en, wrap, offset};
            n_chk++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t {state,busy,rst,en,wrap,offset} got %h required %h",
                         $time, act_vec, exp_vec);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_count(input int v, input string name);
        for (int i = 0; i < 4000 && count1 != v; i++) step();
        check(name, 32'(count1), v);
    endtask

    task automatic wait_wrap(input string name);
        for (int i = 0; i < 4000 && wrap !== 1'b1; i++) step();
        check(name, 32'(wrap), 1);
    endtask

    typedef struct packed {
        logic       start;
        logic       stop;
        logic [7:0] div;
        logic [1:0] e_state;
        logic       e_rst;
        logic       e_en;
    } vec_t;

    vec_t tv [16];

    initial begin
        tv[0]  = '{1'b1, 1'b1, 8'd2, 2'd0, 1'b0, 1'b0};  // start+stop in IDLE
        tv[1]  = '{1'b1, 1'b0, 8'd2, 2'd1, 1'b1, 1'b0};
        tv[2]  = '{1'b0, 1'b1, 8'd2, 2'd0, 1'b0, 1'b0};  // stop during CLEAR
        tv[3]  = '{1'b0, 1'b0, 8'd2, 2'd0, 1'b0, 1'b0};
        tv[4]  = '{1'b1, 1'b0, 8'd2, 2'd1, 1'b1, 1'b0};
        tv[5]  = '{1'b0, 1'b0, 8'd2, 2'd2, 1'b0, 1'b1};
        tv[6]  = '{1'b0, 1'b0, 8'd2, 2'd2, 1'b0, 1'b0};
        tv[7]  = '{1'b0, 1'b0, 8'd2, 2'd2, 1'b0, 1'b0};
        tv[8]  = '{1'b0, 1'b0, 8'd2, 2'd2, 1'b0, 1'b1};
        tv[9]  = '{1'b1, 1'b0, 8'd2, 2'd2, 1'b0, 1'b0};  // start in RUN ignored
        tv[10] = '{1'b0, 1'b0, 8'd2, 2'd2, 1'b0, 1'b0};
        tv[11] = '{1'b0, 1'b0, 8'd2, 2'd2, 1'b0, 1'b1};
        tv[12] = '{1'b0, 1'b0, 8'd0, 2'd2, 1'b0, 1'b1};
        tv[13] = '{1'b0, 1'b0, 8'd0, 2'd2, 1'b0, 1'b1};
        tv[14] = '{1'b0, 1'b1, 8'd0, 2'd3, 1'b0, 1'b1};
        tv[15] = '{1'b0, 1'b0, 8'd0, 2'd3, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        check("reset_state", 32'(state), 0);
        check("reset_cnt_en", 32'(cnt_en), 0);
        check("reset_offset", 32'(offset), 0);
        check("reset_cnt_rst", 32'(cnt_rst), 0);

        for (int i = 0; i < 16; i++) begin
            start = tv[i].start;
            stop  = tv[i].stop;
            div   = tv[i].div;
            step();
            check($sformatf("vec%0d_state", i), 32'(state), 32'(tv[i].e_state));
            check($sformatf("vec%0d_cnt_rst", i), 32'(cnt_rst), 32'(tv[i].e_rst));
            check($sformatf("vec%0d_cnt_en", i), 32'(cnt_en), 32'(tv[i].e_en));
        end
        start = 1'b0;
        stop  = 1'b0;
        wait_wrap("vec_hold_wrap");
        step();
        check("vec_hold_idle", 32'(state), 0);

        // Stop mid-period with div=0.
        div = 8'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_count(100, "stop_reach_100");
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_hold_state", 32'(state), 3);
        wait_wrap("stop_wrap");
        check("stop_wrap_count", 32'(count1), 511);
        check("stop_wrap_state", 32'(state), 3);
        step();
        check("stop_idle_state", 32'(state), 0);
        check("stop_idle_en", 32'(cnt_en), 0);
        check("stop_idle_busy", 32'(busy), 0);
        repeat (5) step();
        check("stop_idle_en_later", 32'(cnt_en), 0);

        // Offset loads deferred to the wrap, last load wins.
        start = 1'b1;
        step();
        start = 1'b0;
        wait_count(10, "ld_reach_10");
        offset_ld = 1'b1;
        offset_in = 8'd64;
        step();
        offset_ld = 1'b0;
        check("ld_deferred", 32'(offset), 0);
        wait_count(200, "ld_reach_200");
        offset_ld = 1'b1;
        offset_in = 8'd128;
        step();
        offset_ld = 1'b0;
        wait_wrap("ld_wrap1");
        check("ld_before_wrap", 32'(offset), 0);
        step();
        check("ld_last_wins", 32'(offset), 128);
        wait_count(10, "ld_reach_10b");
        offset_ld = 1'b1;
        offset_in = 8'd64;
        step();
        offset_ld = 1'b0;
        wait_wrap("ld_wrap2");
        step();
        check("ld_single", 32'(offset), 64);

        // Sweep, including 255 -> 0 and a coincident load.
        wait_count(10, "sw_reach_10");
        offset_ld = 1'b1;
        offset_in = 8'd254;
        sweep = 1'b1;
        step();
        offset_ld = 1'b0;
        wait_wrap("sw_wrap0");
        step();
        check("sw_pend_beats_sweep", 32'(offset), 254);
        wait_wrap("sw_wrap1");
        step();
        check("sw_step_255", 32'(offset), 255);
        wait_wrap("sw_wrap2");
        step();
        check("sw_step_0", 32'(offset), 0);
        wait_wrap("sw_wrap3");
        offset_ld = 1'b1;
        offset_in = 8'd7;
        step();
        offset_ld = 1'b0;
        check("sw_coincident_load", 32'(offset), 7);
        sweep = 1'b0;

        // Asynchronous reset mid-RUN at div=3.
        div = 8'd3;
        repeat (20) step();
        check("pre_reset_state", 32'(state), 2);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_state", 32'(state), 0);
        check("async_reset_en", 32'(cnt_en), 0);
        check("async_reset_offset", 32'(offset), 0);
        check("async_reset_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Random traffic against the reference model.
        div = 8'd0;
        for (int c = 0; c < 40000; c++) begin
            start     = ($urandom_range(199) == 0);
            stop      = ($urandom_range(2999) == 0);
            offset_ld = ($urandom_range(299) == 0);
            offset_in = 8'($urandom);
            if ($urandom_range(1999) == 0) sweep = ~sweep;
            if ($urandom_range(499) == 0) div = 8'($urandom_range(1));
            step();
        end
        start = 1'b0;
        stop = 1'b0;
        offset_ld = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sig_ctrl.md
Name: sig_ctrl

Overview:
- Sequencing controller for the dual-output address counter of the signal generator (count1/count2 feeding the dual-port waveform ROM).
- Drives the counter's clear, enable and phase-offset inputs.
- Provides start/stop control, a programmable rate prescaler, period-aligned offset updates, and an optional phase-sweep mode.
- Sits between the Vbuddy/top-level controls and the counter instance.

Parameters:
- WIDTH, 9, counter width; count1 input width.
- OFF_W, 8, offset width (WIDTH-1).
- DIV_W, 8, prescaler divide-value width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle start request
- stop  in  1  single-cycle stop request
- div  in  DIV_W  rate select; one enable strobe every div+1 cycles
- offset_in  in  OFF_W  requested phase offset
- offset_ld  in  1  single-cycle load strobe for offset_in
- sweep  in  1  level; auto-increment offset once per period
- count1  in  WIDTH  current count1 from the counter
- cnt_rst  out  1  active-high synchronous clear to the counter
- cnt_en  out  1  enable to the counter
- offset  out  OFF_W  offset to the counter
- wrap  out  1  period-boundary strobe
- busy  out  1  high in CLEAR, RUN or HOLD
- state  out  2  current FSM state, for debug/Vbuddy display

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, div_cnt=0, offset=0, pend_val=0, pend=0.
  - All outputs 0.
- FSM states are IDLE, CLEAR, RUN and HOLD. stop has priority over start in the same cycle.
  - IDLE: start -> CLEAR. stop is ignored.
  - CLEAR (one cycle): cnt_rst=1, div_cnt<=0. Next state is RUN, or IDLE if stop is high.
  - RUN: stop -> HOLD. start is ignored.
  - HOLD: keep strobing until the wrap event, then -> IDLE on that edge. start and stop are ignored.
- Prescaler (RUN/HOLD only):
  - cnt_en = (state is RUN or HOLD) && div_cnt==0. Decoded from registers, no input-to-output path.
  - On a strobe, div_cnt<=div, with div sampled at that edge. Otherwise div_cnt<=div_cnt-1.
  - div=0 gives cnt_en every cycle.
  - The first strobe occurs in the first RUN cycle.
- Wrap event:
  - wrap = cnt_en && count1==all-ones. This is combinational; the counter returns to 0 at that edge.
  - A period at div=D is 2^WIDTH*(D+1) cycles.
- Offset, when in IDLE or CLEAR:
  - offset_ld -> offset<=offset_in at the next edge.
  - The pending register is unused.
- Offset, when in RUN or HOLD:
  - offset_ld -> pend<=offset_in, pend_val<=1. A later load overwrites pend (last wins).
  - On a wrap event with pend_val=1: offset<=pend, pend_val<=0.
  - offset_ld coincident with wrap: offset<=offset_in directly and pend_val<=0.
  - Otherwise, on a wrap event with sweep=1: offset<=offset+1, modulo 2^OFF_W (255 -> 0).
  - A pending or coincident load beats sweep.
- Leaving HOLD for IDLE:
  - The pending update is applied on the final wrap.
  - Offset is retained in IDLE.
- Asynchronous reset mid-RUN or mid-HOLD returns immediately to the reset values.
  - The counter's own clear is the integrator's responsibility, via the next start/CLEAR.

Decomposition:
- Package sig_ctrl_pkg contains:
  - typedef enum logic [1:0] {IDLE=0, CLEAR=1, RUN=2, HOLD=3} state_t
  - default width constants (WIDTH, OFF_W, DIV_W)
- One natural sub-module: sig_prescaler, the div_cnt down-counter.
  - Inputs: clk, rst, run, div.
  - Output: tick (cnt_en).
- FSM and offset logic remain in sig_ctrl.

Test Plan:
1. Reset:
   - Stimulus: rst low mid-RUN with div=3.
   - Required: state=0, cnt_en=0, offset=0 immediately, without waiting for a clk edge.
2. Start with div=2:
   - Stimulus: start pulse.
   - Required: cnt_rst=1 for exactly one cycle, then cnt_en pattern 1,0,0,1,0,0…
   - With div=0: cnt_en=1 every RUN cycle.
3. Stop mid-period:
   - Stimulus: stop at count1=100, div=0.
   - Required: state=HOLD, strobes continue to count1=511; wrap=1 on that cycle; state=IDLE next cycle; cnt_en=0 thereafter.
4. Offset load in RUN:
   - Stimulus: offset=0, offset_ld with offset_in=64 at count1=10.
   - Required: offset stays 0 until the wrap edge at count1=511, then offset=64.
   - Second load (128) before wrap: 128 is applied instead.
5. Sweep:
   - Stimulus: sweep=1, offset=254, div=0.
   - Required: offset steps to 255 after one period (512 strobes), then to 0 after the next period.
   - A coincident offset_ld=7 at a wrap yields 7, not an increment.
6. Simultaneous start+stop:
   - In IDLE: stays IDLE.
   - stop during CLEAR: -> IDLE with no cnt_en strobe.
   - start in RUN: no second cnt_rst pulse.
